// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the instruction/data SRAM arbiter: bus widths
// (RegBus, InstAddrBus), the full-word byte-enable pattern used for fetches,
// and the arbiter state encoding.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Shares one single-port SRAM between the instruction-fetch port and the
// data port.  Data requests have fixed priority over fetches.  Writes finish
// in their issue cycle; reads take an issue cycle plus a response cycle.
// Finished results are held (done flag + hold register) until the pipeline
// stops stalling, so each completed result is consumed exactly once.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   if_ce_i/if_addr_i    fetch request (level) and word address
//   if_data_o/if_ready_o fetched word and completion
//   dm_ce_i/dm_we_i/dm_sel_i/dm_addr_i/dm_data_i   data request
//   dm_data_o/dm_ready_o load data and completion
//   sram_*_o / sram_data_i  SRAM strobe, controls and read data (next cycle)
//   stallreq_o           stall request to the pipeline
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | free; may issue one access (data first, then fetch)
// ST_RD_IF | fetch read outstanding; sram_data_i is the instruction
// ST_RD_DM | data read outstanding; sram_data_i is the load data
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W,
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,

    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic [DATA_W-1:0] dm_data_o,
    output logic              dm_ready_o,

    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [3:0]        sram_sel_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_data_o,
    input  logic [DATA_W-1:0] sram_data_i,

    output logic              stallreq_o
);

    arb_state_e        state;
    logic              if_done;
    logic              dm_done;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] dm_hold;
    logic              rst_q;

    logic              blocked;
    logic              issue_dm;
    logic              issue_if;
    logic              rd_if_now;
    logic              rd_dm_now;

    // Nothing is issued while reset is asserted nor in the first cycle after
    // it, so a request held across reset starts on a clean cycle.
    assign blocked   = rst | rst_q;
    assign issue_dm  = (state == ST_IDLE) & ~blocked & dm_ce_i & ~dm_done;
    assign issue_if  = (state == ST_IDLE) & ~blocked & if_ce_i & ~if_done & ~issue_dm;
    assign rd_if_now = (state == ST_RD_IF) & ~rst;
    assign rd_dm_now = (state == ST_RD_DM) & ~rst;

    always_comb begin
        sram_ce_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_sel_o  = 4'b0000;
        sram_addr_o = '0;
        sram_data_o = '0;
        if (issue_dm) begin
            sram_ce_o   = 1'b1;
            sram_we_o   = dm_we_i;
            sram_sel_o  = dm_sel_i;
            sram_addr_o = dm_addr_i;
            sram_data_o = dm_data_i;
        end else if (issue_if) begin
            sram_ce_o   = 1'b1;
            sram_sel_o  = SEL_WORD;
            sram_addr_o = if_addr_i;
        end
    end

    assign dm_ready_o = ~rst & (dm_done | rd_dm_now | (issue_dm & dm_we_i));
    assign if_ready_o = ~rst & (if_done | rd_if_now);
    assign dm_data_o  = rst ? '0 : (rd_dm_now ? sram_data_i : dm_hold);
    assign if_data_o  = rst ? '0 : (rd_if_now ? sram_data_i : if_hold);

    assign stallreq_o = (if_ce_i & ~if_ready_o) | (dm_ce_i & ~dm_ready_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if_hold <= '0;
            dm_hold <= '0;
            rst_q   <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue_dm && !dm_we_i) begin
                        state <= ST_RD_DM;
                    end else if (issue_if) begin
                        state <= ST_RD_IF;
                    end
                end
                ST_RD_IF: begin
                    if_hold <= sram_data_i;
                    state   <= ST_IDLE;
                end
                ST_RD_DM: begin
                    dm_hold <= sram_data_i;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // A result is parked only while the pipeline is still stalled by
            // the other port; a dropped request never leaves a flag behind.
            dm_done <= stallreq_o & dm_ce_i & dm_ready_o;
            if_done <= stallreq_o & if_ce_i & if_ready_o;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_i;
    logic [31:0] dm_data_o;
    logic        dm_ready_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM contents (1024 words, byte address bits [11:2])
    logic [31:0] mem [0:1023];

    bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .if_ce_i     (if_ce_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .dm_ce_i     (dm_ce_i),
        .dm_we_i     (dm_we_i),
        .dm_sel_i    (dm_sel_i),
        .dm_addr_i   (dm_addr_i),
        .dm_data_i   (dm_data_i),
        .dm_data_o   (dm_data_o),
        .dm_ready_o  (dm_ready_o),
        .sram_ce_o   (sram_ce_o),
        .sram_we_o   (sram_we_o),
        .sram_sel_o  (sram_sel_o),
        .sram_addr_o (sram_addr_o),
        .sram_data_o (sram_data_o),
        .sram_data_i (sram_data_i),
        .stallreq_o  (stallreq_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [9:0] idx);
        return mem[idx];
    endfunction

    // SRAM model: strobe seen before the edge, response/write applied at it
    initial begin
        logic       s_rd;
        logic       s_wr;
        logic [9:0] s_idx;
        logic [3:0] s_sel;
        logic [31:0] s_wd;
        for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        mem[1]   = 32'h3401_0020;
        mem[2]   = 32'h0000_0000;
        mem[128] = 32'h1234_5678;
        sram_data_i = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            s_rd  = sram_ce_o && !sram_we_o;
            s_wr  = sram_ce_o && sram_we_o;
            s_idx = sram_addr_o[11:2];
            s_sel = sram_sel_o;
            s_wd  = sram_data_o;
            @(posedge clk);
            if (s_rd) sram_data_i <= mem[s_idx];
            else      sram_data_i <= $urandom;
            if (s_wr) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_idx][8*b +: 8] = s_wd[8*b +: 8];
            end
        end
    end

    // Reference model: tracks which port owns an outstanding read, the
    // parked results and the post-reset dead cycle; checks every cycle.
    int          m_owner     = 0;       // 0 none, 1 fetch, 2 data
    logic        m_if_done   = 1'b0;
    logic        m_dm_done   = 1'b0;
    logic [31:0] m_if_hold   = '0;
    logic [31:0] m_dm_hold   = '0;
    logic [31:0] m_rd_data   = '0;
    logic        m_after_rst = 1'b0;
    logic        m_stall_last = 1'b0;

    initial begin
        logic        blk, w_dm, w_if;
        logic        e_ce, e_we, e_if_rdy, e_dm_rdy, e_stall;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wd, e_if_dat, e_dm_dat;
        forever begin
            @(negedge clk);
            blk  = rst || m_after_rst;
            w_dm = !blk && m_owner == 0 && dm_ce_i && !m_dm_done;
            w_if = !blk && m_owner == 0 && if_ce_i && !m_if_done && !w_dm;
            e_ce   = w_dm || w_if;
            e_we   = w_dm && dm_we_i;
            e_sel  = w_dm ? dm_sel_i : (w_if ? 4'hF : 4'h0);
            e_addr = w_dm ? dm_addr_i : (w_if ? if_addr_i : 32'h0);
            e_wd   = w_dm ? dm_data_i : 32'h0;
            e_dm_rdy = !rst && (m_dm_done || m_owner == 2 || (w_dm && dm_we_i));
            e_if_rdy = !rst && (m_if_done || m_owner == 1);
            e_dm_dat = rst ? 32'h0 : (m_owner == 2 ? m_rd_data : m_dm_hold);
            e_if_dat = rst ? 32'h0 : (m_owner == 1 ? m_rd_data : m_if_hold);
            e_stall  = (if_ce_i && !e_if_rdy) || (dm_ce_i && !e_dm_rdy);

            chk_val("mon_sram_ce",   32'(sram_ce_o),  32'(e_ce));
            chk_val("mon_sram_we",   32'(sram_we_o),  32'(e_we));
            chk_val("mon_sram_sel",  32'(sram_sel_o), 32'(e_sel));
            chk_val("mon_sram_addr", sram_addr_o,     e_addr);
            chk_val("mon_sram_wd",   sram_data_o,     e_wd);
            chk_val("mon_if_ready",  32'(if_ready_o), 32'(e_if_rdy));
            chk_val("mon_if_data",   if_data_o,       e_if_dat);
            chk_val("mon_dm_ready",  32'(dm_ready_o), 32'(e_dm_rdy));
            chk_val("mon_dm_data",   dm_data_o,       e_dm_dat);
            chk_val("mon_stall",     32'(stallreq_o), 32'(e_stall));
            m_stall_last = e_stall;

            if (rst) begin
                m_owner = 0; m_if_done = 0; m_dm_done = 0;
                m_if_hold = '0; m_dm_hold = '0; m_after_rst = 1'b1;
            end else begin
                m_after_rst = 1'b0;
                m_dm_done = e_stall && dm_ce_i && e_dm_rdy;
                m_if_done = e_stall && if_ce_i && e_if_rdy;
                if (m_owner == 2) m_dm_hold = m_rd_data;
                if (m_owner == 1) m_if_hold = m_rd_data;
                if (w_dm && !dm_we_i) begin
                    m_owner = 2; m_rd_data = mem_rd(dm_addr_i[11:2]);
                end else if (w_if) begin
                    m_owner = 1; m_rd_data = mem_rd(if_addr_i[11:2]);
                end else begin
                    m_owner = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_ce_i = 1'b1; if_addr_i = 32'h0;
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF;
        dm_addr_i = 32'h40; dm_data_i = 32'h0;

        // reset behaviour with both requests held
        @(negedge clk);
        chk_val("rst_sram_ce",  32'(sram_ce_o),  32'd0);
        chk_val("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk_val("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk_val("rst_dm_data",  dm_data_o,       32'd0);
        chk_val("rst_stall",    32'(stallreq_o), 32'd1);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk_val("post_rst_ce",    32'(sram_ce_o),  32'd0);
        chk_val("post_rst_ready", 32'(dm_ready_o), 32'd0);
        chk_val("post_rst_data",  if_data_o,       32'd0);
        tick(); if_ce_i = 1'b0; dm_ce_i = 1'b0;
        @(negedge clk);
        chk_val("idle_ce",    32'(sram_ce_o),  32'd0);
        chk_val("idle_stall", 32'(stallreq_o), 32'd0);

        // fetch only
        tick(); if_ce_i = 1'b1; if_addr_i = 32'h4;
        @(negedge clk);
        chk_val("fetch_c1_ce",    32'(sram_ce_o),  32'd1);
        chk_val("fetch_c1_addr",  sram_addr_o,     32'h4);
        chk_val("fetch_c1_sel",   32'(sram_sel_o), 32'hF);
        chk_val("fetch_c1_stall", 32'(stallreq_o), 32'd1);
        tick();
        @(negedge clk);
        chk_val("fetch_c2_ready", 32'(if_ready_o), 32'd1);
        chk_val("fetch_c2_data",  if_data_o,       32'h3401_0020);
        chk_val("fetch_c2_stall", 32'(stallreq_o), 32'd0);
        tick(); if_ce_i = 1'b0;
        @(negedge clk);
        chk_val("fetch_c3_ready", 32'(if_ready_o), 32'd0);

        // store
        tick(); dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
        dm_addr_i = 32'h100; dm_data_i = 32'h0000_BEEF;
        @(negedge clk);
        chk_val("store_we",    32'(sram_we_o),  32'd1);
        chk_val("store_sel",   32'(sram_sel_o), 32'h3);
        chk_val("store_addr",  sram_addr_o,     32'h100);
        chk_val("store_wd",    sram_data_o,     32'h0000_BEEF);
        chk_val("store_ready", 32'(dm_ready_o), 32'd1);
        chk_val("store_stall", 32'(stallreq_o), 32'd0);
        tick(); dm_ce_i = 1'b0; dm_we_i = 1'b0; dm_sel_i = 4'hF;
        @(negedge clk);
        chk_val("store_after_ready", 32'(dm_ready_o), 32'd0);

        // load and fetch collide
        tick(); dm_ce_i = 1'b1; dm_addr_i = 32'h200; if_ce_i = 1'b1; if_addr_i = 32'h8;
        @(negedge clk);
        chk_val("coll_c1_addr",  sram_addr_o,     32'h200);
        chk_val("coll_c1_stall", 32'(stallreq_o), 32'd1);
        tick();
        @(negedge clk);
        chk_val("coll_c2_dm_ready", 32'(dm_ready_o), 32'd1);
        chk_val("coll_c2_dm_data",  dm_data_o,       32'h1234_5678);
        chk_val("coll_c2_stall",    32'(stallreq_o), 32'd1);
        tick();
        @(negedge clk);
        chk_val("coll_c3_ce",      32'(sram_ce_o),  32'd1);
        chk_val("coll_c3_addr",    sram_addr_o,     32'h8);
        chk_val("coll_c3_dm_data", dm_data_o,       32'h1234_5678);
        chk_val("coll_c3_stall",   32'(stallreq_o), 32'd1);
        tick();
        @(negedge clk);
        chk_val("coll_c4_if_ready", 32'(if_ready_o), 32'd1);
        chk_val("coll_c4_if_data",  if_data_o,       32'h0);
        chk_val("coll_c4_dm_data",  dm_data_o,       32'h1234_5678);
        chk_val("coll_c4_stall",    32'(stallreq_o), 32'd0);
        tick(); dm_ce_i = 1'b0; if_ce_i = 1'b0;

        // back-to-back loads
        dm_ce_i = 1'b1; dm_addr_i = 32'h10;
        @(negedge clk);
        chk_val("b2b_1_addr",  sram_addr_o,     32'h10);
        chk_val("b2b_1_ready", 32'(dm_ready_o), 32'd0);
        tick();
        @(negedge clk);
        chk_val("b2b_2_ready", 32'(dm_ready_o), 32'd1);
        chk_val("b2b_2_data",  dm_data_o,       mem_rd(10'd4));
        chk_val("b2b_2_stall", 32'(stallreq_o), 32'd0);
        tick(); dm_addr_i = 32'h14;
        @(negedge clk);
        chk_val("b2b_3_ce",    32'(sram_ce_o),  32'd1);
        chk_val("b2b_3_addr",  sram_addr_o,     32'h14);
        chk_val("b2b_3_ready", 32'(dm_ready_o), 32'd0);
        tick();
        @(negedge clk);
        chk_val("b2b_4_data", dm_data_o, mem_rd(10'd5));
        tick(); dm_ce_i = 1'b0;

        // reset during a data read
        dm_ce_i = 1'b1; dm_addr_i = 32'h20;
        @(negedge clk);
        chk_val("rrd_issue_ce", 32'(sram_ce_o), 32'd1);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk_val("rrd_rst_ready", 32'(dm_ready_o), 32'd0);
        chk_val("rrd_rst_data",  dm_data_o,       32'd0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk_val("rrd_post_ce",    32'(sram_ce_o),  32'd0);
        chk_val("rrd_post_ready", 32'(dm_ready_o), 32'd0);
        chk_val("rrd_post_data",  dm_data_o,       32'd0);
        tick();
        @(negedge clk);
        chk_val("rrd_reissue_ce",   32'(sram_ce_o), 32'd1);
        chk_val("rrd_reissue_addr", sram_addr_o,    32'h20);
        tick();
        @(negedge clk);
        chk_val("rrd_done_data", dm_data_o, mem_rd(10'd8));
        tick(); dm_ce_i = 1'b0;

        // fetch request dropped mid-read
        if_ce_i = 1'b1; if_addr_i = 32'hC;
        @(negedge clk);
        chk_val("drop_issue_ce", 32'(sram_ce_o), 32'd1);
        tick(); if_ce_i = 1'b0;
        @(negedge clk);
        chk_val("drop_rd_ce", 32'(sram_ce_o), 32'd0);
        tick();
        @(negedge clk);
        chk_val("drop_after_ready", 32'(if_ready_o), 32'd0);
        chk_val("drop_after_stall", 32'(stallreq_o), 32'd0);
        tick(); if_ce_i = 1'b1; if_addr_i = 32'h18;
        @(negedge clk);
        chk_val("drop_new_ce",   32'(sram_ce_o), 32'd1);
        chk_val("drop_new_addr", sram_addr_o,    32'h18);
        tick();
        @(negedge clk);
        chk_val("drop_new_ready", 32'(if_ready_o), 32'd1);
        tick(); if_ce_i = 1'b0;

        // randomized pipeline traffic; requests change only when not stalled
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            if (!m_stall_last) begin
                if_ce_i   = ($urandom_range(0, 2) != 0);
                if_addr_i = 32'($urandom_range(0, 31)) << 2;
                dm_ce_i   = ($urandom_range(0, 2) != 0);
                dm_we_i   = ($urandom_range(0, 1) == 1);
                dm_sel_i  = 4'($urandom_range(1, 15));
                dm_addr_i = 32'($urandom_range(0, 31)) << 2;
                dm_data_i = $urandom;
            end else begin
                if ($urandom_range(0, 29) == 0) dm_ce_i = 1'b0;
                if ($urandom_range(0, 29) == 0) if_ce_i = 1'b0;
            end
        end
        tick();
        rst = 1'b0; if_ce_i = 1'b0; dm_ce_i = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
